// File: rtl/aurora_pkg.sv
// aurora_pkg: shared block type, sync/idle/seed constants and the 64-bit scrambler step
package aurora_pkg;

    localparam logic [1:0]  SYNC_DATA         = 2'b01;
    localparam logic [1:0]  SYNC_CTRL         = 2'b10;
    localparam logic [63:0] IDLE_WORD_DEFAULT = 64'h7800_0000_0000_0000;
    localparam logic [57:0] SCR_SEED_DEFAULT  = 58'h3FF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [1:0]  sync;
        logic [63:0] payload;
    } block66_t;

    typedef struct packed {
        logic [63:0] data;
        logic [57:0] state;
    } scr_t;

    // One 64-bit advance of x^58+x^39+1: h = {s, state}, state[0] oldest,
    // so h[58+i] = s[i] and the taps reach 39 and 58 bits back.
    function automatic scr_t scramble(input logic [63:0] d, input logic [57:0] st);
        logic [121:0] h;
        scr_t r;
        h = {64'b0, st};
        for (int i = 0; i < 64; i++) begin
            h[58+i] = d[i] ^ h[i+19] ^ h[i];
        end
        r.data  = h[121:58];
        r.state = h[121:64];
        return r;
    endfunction

endpackage

// File: rtl/aurora_tx_fifo.sv
// aurora_tx_fifo: power-of-two synchronous FIFO of 66-bit blocks, async active-low reset
module aurora_tx_fifo
    import aurora_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  block66_t din_i,
    input  logic     pop_i,
    output block66_t dout_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    block66_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; reads are gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/aurora_tx_framer.sv
// aurora_tx_framer: buffers 66-bit blocks, scrambles them (idle fill when empty) for the 66-to-20 gearbox; optional AURORA_TX_STATS_EN adds IdleCnt/StallSeen
module aurora_tx_framer
    import aurora_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] IDLE_WORD  = IDLE_WORD_DEFAULT,
    parameter logic [57:0] SCR_SEED   = SCR_SEED_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] DataIn,
    input  logic [1:0]  SyncIn,
    input  logic        ValidIn,
    output logic        ReadyOut,
    input  logic        DataNext,
`ifdef AURORA_TX_STATS_EN
    output logic [15:0] IdleCnt,
    output logic [0:0]  StallSeen,
`endif
    output logic [65:0] Data66
);

    localparam block66_t IDLE_BLK = {SYNC_CTRL, IDLE_WORD};

    block66_t    head, src;
    scr_t        scr;
    logic        full, empty, push;
    logic [65:0] data_q, data_d;
    logic [57:0] state_q, state_d;

    assign ReadyOut = Rst & ~full;
    assign push     = ValidIn & ReadyOut;
    assign Data66   = data_q;

    aurora_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Rst),
        .push_i  (push),
        .din_i   ({SyncIn, DataIn}),
        .pop_i   (DataNext),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Each DataNext picks the FIFO head or an idle block and scrambles only its payload.
    always_comb begin
        src     = empty ? IDLE_BLK : head;
        scr     = scramble(src.payload, state_q);
        data_d  = DataNext ? {src.sync, scr.data} : data_q;
        state_d = DataNext ? scr.state : state_q;
    end

    // Output word and scrambler state; reset presents the unscrambled idle block.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_q  <= IDLE_BLK;
            state_q <= SCR_SEED;
        end else begin
            data_q  <= data_d;
            state_q <= state_d;
        end
    end

`ifdef AURORA_TX_STATS_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        stall_q, stall_d;

    assign IdleCnt   = idle_cnt_q;
    assign StallSeen = stall_q;

    // Saturating idle-insertion count and sticky backpressure flag.
    always_comb begin
        idle_cnt_d = (DataNext & empty & ~&idle_cnt_q) ? idle_cnt_q + 16'd1 : idle_cnt_q;
        stall_d    = stall_q | (ValidIn & ~ReadyOut);
    end

    // Statistics registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            idle_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            stall_q    <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_aurora_tx_framer.sv
// tb_aurora_tx_framer: directed and random checks of the TX framer against a serial scrambler model
module tb_aurora_tx_framer;
    import aurora_pkg::*;

    localparam logic [65:0] IDLE66 = {SYNC_CTRL, IDLE_WORD_DEFAULT};

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [63:0] DataIn = '0;
    logic [1:0]  SyncIn = '0;
    logic        ValidIn = 1'b0;
    logic        DataNext = 1'b0;
    logic        ReadyOut;
    logic [65:0] Data66;
`ifdef AURORA_TX_STATS_EN
    logic [15:0] IdleCnt;
    logic [0:0]  StallSeen;
`endif

    aurora_tx_framer dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .DataIn   (DataIn),
        .SyncIn   (SyncIn),
        .ValidIn  (ValidIn),
        .ReadyOut (ReadyOut),
        .DataNext (DataNext),
`ifdef AURORA_TX_STATS_EN
        .IdleCnt  (IdleCnt),
        .StallSeen(StallSeen),
`endif
        .Data66   (Data66)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    int          rx = 0;
    int          sent = 0;
    int          cyc = 0;
    logic        pv = 1'b0;
    logic        rdy_now;
    logic [65:0] pb;
    logic [65:0] mq [$];
    logic [65:0] tq [$];
    logic [57:0] msr, dsr;
    logic [65:0] last;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serial history: sr[k] is the scrambled bit sent k+1 bits ago.
    task automatic reseed();
        logic [57:0] sd;
        sd = SCR_SEED_DEFAULT;
        for (int k = 0; k < 58; k++) msr[k] = sd[57-k];
        dsr  = msr;
        last = IDLE66;
        mq.delete();
        tq.delete();
    endtask

    task automatic mscr(input logic [63:0] d, output logic [63:0] s);
        for (int i = 0; i < 64; i++) begin
            s[i] = d[i] ^ msr[38] ^ msr[57];
            msr  = {msr[56:0], s[i]};
        end
    endtask

    task automatic dscr(input logic [63:0] s, output logic [63:0] d);
        for (int i = 0; i < 64; i++) begin
            d[i] = s[i] ^ dsr[38] ^ dsr[57];
            dsr  = {dsr[56:0], s[i]};
        end
    endtask

    // One clock: drive, check ReadyOut, take the edge, update the model, check Data66.
    task automatic cycle(input logic v, input logic [1:0] sy, input logic [63:0] d, input logic dn);
        logic        rdy;
        logic [65:0] blk, got;
        logic [63:0] s, dd;
        ValidIn  = v;
        SyncIn   = sy;
        DataIn   = d;
        DataNext = dn;
        rdy = Rst && mq.size() < 4;
        #1;
        chk("ready", {65'b0, ReadyOut}, {65'b0, rdy});
        @(posedge Clk);
        #1;
        if (dn && Rst) begin
            blk = mq.size() != 0 ? mq.pop_front() : IDLE66;
            mscr(blk[63:0], s);
            last = {blk[65:64], s};
            dscr(Data66[63:0], dd);
            got = {Data66[65:64], dd};
            if (got != IDLE66) begin
                chk("descr", got, tq.size() != 0 ? tq.pop_front() : 66'bx);
                rx++;
            end
        end
        if (v && rdy) begin
            mq.push_back({sy, d});
            tq.push_back({sy, d});
        end
        chk(dn ? "data66" : "hold", Data66, last);
        ValidIn  = 1'b0;
        DataNext = 1'b0;
    endtask

    initial begin
        reseed();
        cycle(0, 2'b00, 64'd0, 0);
        cycle(0, 2'b00, 64'd0, 1);
        Rst = 1'b1;

        // idle fill from the seed
        repeat (6) cycle(0, 2'b00, 64'd0, 1);

        // fill to full, hold a fifth block, pop one, accept the held block
        for (int i = 1; i <= 4; i++) cycle(1, SYNC_DATA, 64'(i), 0);
        cycle(1, SYNC_DATA, 64'd5, 0);
        cycle(1, SYNC_DATA, 64'd5, 1);
        cycle(1, SYNC_DATA, 64'd5, 0);
        repeat (5) cycle(0, 2'b00, 64'd0, 1);

        // push into empty on a DataNext edge: idle first, block next
        cycle(1, SYNC_DATA, 64'hA5A5_5A5A_0123_4567, 1);
        cycle(0, 2'b00, 64'd0, 1);

        // full with ValidIn and DataNext both high
        for (int i = 0; i < 4; i++) cycle(1, SYNC_CTRL, 64'hF00 + 64'(i), 0);
        cycle(1, 2'b11, 64'hBEEF, 1);
        cycle(1, 2'b11, 64'hBEEF, 0);
        repeat (5) cycle(0, 2'b00, 64'd0, 1);

        // random stream at 2-of-3 DataNext cadence
        rx = 0;
        while ((sent < 100 || mq.size() != 0) && cyc < 2000) begin
            if (!pv && sent < 100) begin
                pb = {($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL, $urandom, $urandom};
                pv = 1'b1;
            end
            rdy_now = mq.size() < 4;
            cycle(pv, pb[65:64], pb[63:0], (cyc % 3) != 2);
            if (pv && rdy_now) begin
                pv = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("stream_bound", {65'b0, cyc < 2000}, 66'd1);
        chk("stream_rx", 66'(rx), 66'd100);
        chk("stream_left", 66'(tq.size()), 66'd0);

        // reset mid-stream with three blocks buffered
        for (int i = 0; i < 3; i++) cycle(1, SYNC_DATA, 64'hC0DE + 64'(i), 0);
        Rst = 1'b0;
        #1;
        chk("rst_data66", Data66, IDLE66);
        chk("rst_ready", {65'b0, ReadyOut}, 66'd0);
        reseed();
        cycle(0, 2'b00, 64'd0, 0);
        Rst = 1'b1;
        repeat (2) cycle(0, 2'b00, 64'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_tx_framer.md
Name: aurora_tx_framer

Overview:
- Upstream feeder of the 66-to-20 gearbox in the Aurora 64b66b TX path.
- Accepts 64-bit blocks with 2-bit sync headers from the chip output logic over a valid/ready handshake and buffers them in a small FIFO.
- Scrambles the payload with the x^58+x^39+1 self-synchronous scrambler and presents a registered 66-bit word that the gearbox consumes on each DataNext pulse.
- Inserts idle blocks when no user block is buffered.

Parameters:
- FIFO_DEPTH, 4, number of 66-bit entries buffered; power of two, minimum 2.
- IDLE_WORD, 64'h7800_0000_0000_0000, payload of the idle control block sent when the FIFO is empty.
- SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded at reset.

Ports:
- Clk  in  1  single clock, shared with the gearbox.
- Rst  in  1  reset; one clock; reset is asynchronous and active-low.
- DataIn  in  64  block payload, bit 0 transmitted first.
- SyncIn  in  2  sync header: 2'b01 = data block, 2'b10 = control block.
- ValidIn  in  1  DataIn/SyncIn valid.
- ReadyOut  out  1  FIFO can accept a block this cycle.
- DataNext  in  1  gearbox load strobe; the gearbox captures Data66 at this edge.
- Data66  out  66  {sync[1:0], scrambled[63:0]}; sync header is never scrambled.

Behaviour:
- Reset (Rst=0, asynchronous):
  - FIFO empty, ReadyOut=0 while Rst is low.
  - Scrambler state = SCR_SEED.
  - Data66 = {2'b10, IDLE_WORD} unscrambled. The gearbox is also in reset and loads this value.
- After reset release: ReadyOut = ~full, combinational from the registered count.
- Push:
  - Occurs when ValidIn & ReadyOut at a rising edge, storing {SyncIn, DataIn}.
  - ValidIn while ReadyOut=0 is ignored. No overflow write occurs; the producer must hold the block.
  - SyncIn of 2'b00 or 2'b11 is stored and transmitted unchanged. The framer does not police it.
- Pop / advance:
  - Occurs only at an edge where DataNext=1.
  - If the FIFO is non-empty, the head entry is popped and scrambled into Data66.
  - If empty, the idle block {2'b10, IDLE_WORD} is scrambled into Data66.
  - Data66 is stable between DataNext edges.
- Latency: a block pushed at edge N can appear on Data66 no earlier than the first DataNext edge after N. The write-to-read path has no same-cycle bypass.
- Simultaneous push and pop:
  - Both take effect and the count is unchanged.
  - If full with DataNext=1, ReadyOut is still 0 that cycle, so no push occurs.
  - Push into an empty FIFO on a DataNext edge: idle is sent at that edge, and the pushed block is sent at the next DataNext.
- Scrambler (64 bits per advance):
  - h = {s[63:0], state[57:0]} with state[0] oldest.
  - s[i] = d[i] ^ h[i+19] ^ h[i].
  - Equivalently s[i] = d[i] ^ s[i-39] ^ s[i-58] in serial order.
  - New state = s[63:6].
  - Applied to idle blocks as well, so the state advances on every DataNext edge.
- Pointers: log2(FIFO_DEPTH) bits with wrap-around, plus a count of log2(FIFO_DEPTH)+1 bits. Full = count==FIFO_DEPTH; empty = count==0.
- Reset mid-stream: FIFO contents are discarded and the scrambler reseeds. No partial word is ever output.

Optional Feature:
- Macro AURORA_TX_STATS_EN.
- When defined, two extra outputs are added:
  - IdleCnt [15:0]: saturating count of idle insertions.
  - StallSeen [0:0]: sticky flag set when ValidIn=1 and ReadyOut=0.
  - Both clear on reset.
- When undefined, the ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package aurora_pkg holds:
  - SYNC_DATA=2'b01 and SYNC_CTRL=2'b10.
  - IDLE_WORD default.
  - SCR_SEED default.
  - typedef block66_t {logic [1:0] sync; logic [63:0] payload}.
  - Scramble function (64-bit data, 58-bit state -> 64-bit data, 58-bit state).
- One natural sub-module: aurora_tx_fifo, a synchronous FIFO of block66_t with push/pop/full/empty/count and async active-low reset.

Test Plan:
- Reset, then 6 DataNext pulses with no input -> Data66[65:64]=2'b10 each time. Payload matches the reference scrambler applied to 7800_0000_0000_0000 from seed 3FF_FFFF_FFFF_FFFF.
- Push 4 blocks (0x0000000000000001..4, SyncIn=01) with DataNext low -> ReadyOut falls to 0 after the 4th. A 5th ValidIn is held and not accepted. Then a DataNext pops block 1 and ReadyOut returns to 1 the next cycle.
- Push on the same edge as DataNext with the FIFO empty -> idle is output at that edge and the pushed block at the following DataNext.
- Full FIFO with ValidIn and DataNext both high -> no push that edge, one pop, count=3. The next edge accepts the held block.
- Stream 100 random blocks at DataNext cadence 2-of-3 cycles -> bench descrambler recovers DataIn/SyncIn in order with no loss or duplication.
- Assert Rst low mid-stream with 3 blocks buffered -> Data66 immediately becomes {10, IDLE_WORD} and the FIFO is empty. After release, the first DataNext output matches a fresh-seed scramble of idle.
